// File: rtl/stalta_trigger_ctrl_pkg.sv
// Shared types and constants for the STA/LTA trigger controller.
package stalta_trigger_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP    = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_HOLDOFF   = 2'd3
  } state_t;

  localparam int FRAC_W = 4;   // Q4.4 threshold fraction bits
  localparam int CMP_W  = 40;  // ratio compare width
  localparam int MAG_W  = 17;  // rectified sample width

endpackage

// File: rtl/stalta_trigger_ctrl_window_sum.sv
// Running magnitude sum over one window; adds the entering tap, drops the leaving tap.
// STALTA_ABS_EN: treat taps as signed and rectify; otherwise taps are unsigned magnitudes.
module window_sum
  import stalta_trigger_ctrl_pkg::*;
#(
  parameter int SIZE = 15
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [15:0]                       entering,
  input  logic [15:0]                       leaving,
  output logic [MAG_W+$clog2(SIZE+1)-1:0]   sum
);

  localparam int SUM_W = MAG_W + $clog2(SIZE + 1);

`ifdef STALTA_ABS_EN
  // Sign-extend to 17 bits before negating so -32768 rectifies to +32768.
  function automatic logic [MAG_W-1:0] mag(input logic [15:0] x);
    logic [MAG_W-1:0] ext;
    ext = {x[15], x};
    mag = x[15] ? (~ext + MAG_W'(1)) : ext;
  endfunction
`else
  function automatic logic [MAG_W-1:0] mag(input logic [15:0] x);
    mag = {1'b0, x};
  endfunction
`endif

  // Zero-filled buffer keeps the sum exact, so modular arithmetic never wraps in practice.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum <= '0;
    end else begin
      sum <= sum + SUM_W'(mag(entering)) - SUM_W'(mag(leaving));
    end
  end

endmodule

// File: rtl/stalta_trigger_ctrl.sv
// STA/LTA event trigger: ratio compare on registered window sums driving a hysteretic FSM with hold-off.
//
// state        | meaning
// ST_WARMUP    | buffer still filling, no detection
// ST_ARMED     | waiting for enable && ratio above onThresh
// ST_TRIGGERED | event in progress, counting its length
// ST_HOLDOFF   | dead time, down-counter loaded from holdoff
module stalta_trigger_ctrl
  import stalta_trigger_ctrl_pkg::*;
#(
  parameter int shortSize = 15,
  parameter int longSize  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] firstShort,
  input  logic [15:0] lastShort,
  input  logic [15:0] firstLong,
  input  logic [15:0] lastLong,
  input  logic        initDone,
  input  logic        enable,
  input  logic [7:0]  onThresh,
  input  logic [7:0]  offThresh,
  input  logic [15:0] holdoff,
  output logic        trigger,
  output logic        triggerStart,
  output logic        eventDone,
  output logic [15:0] eventLength,
  output logic [1:0]  state
);

  localparam int SHORT_W = MAG_W + $clog2(shortSize + 1);
  localparam int LONG_W  = MAG_W + $clog2(longSize + 1);

  logic [SHORT_W-1:0] short_sum;
  logic [LONG_W-1:0]  long_sum;

  window_sum #(.SIZE(shortSize)) u_short_sum (
    .clock    (clock),
    .reset    (reset),
    .entering (firstShort),
    .leaving  (lastShort),
    .sum      (short_sum)
  );

  window_sum #(.SIZE(longSize)) u_long_sum (
    .clock    (clock),
    .reset    (reset),
    .entering (firstLong),
    .leaving  (lastLong),
    .sum      (long_sum)
  );

  logic [CMP_W-1:0] lhs, rhs_on, rhs_off;
  logic             on_hit, off_hit;

  // Cross-multiplied ratio test avoids a divider: short/shortSize vs thresh * long/longSize.
  always_comb begin
    lhs     = (CMP_W'(short_sum) * CMP_W'(longSize)) << FRAC_W;
    rhs_on  = CMP_W'(long_sum) * CMP_W'(shortSize) * CMP_W'(onThresh);
    rhs_off = CMP_W'(long_sum) * CMP_W'(shortSize) * CMP_W'(offThresh);
    on_hit  = (long_sum == '0) ? (short_sum != '0) : (lhs > rhs_on);
    off_hit = lhs < rhs_off;
  end

  state_t      state_q, state_d;
  logic [15:0] hold_cnt;
  logic [15:0] ev_cnt, ev_inc;
  logic        start_d, done_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WARMUP:    if (initDone) state_d = ST_ARMED;
      ST_ARMED:     if (enable && on_hit) state_d = ST_TRIGGERED;
      ST_TRIGGERED: if (off_hit) state_d = ST_HOLDOFF;
      ST_HOLDOFF:   if (hold_cnt == '0) state_d = ST_ARMED;
      default:      state_d = ST_WARMUP;
    endcase
    start_d = (state_q != ST_TRIGGERED) && (state_d == ST_TRIGGERED);
    done_d  = (state_q == ST_TRIGGERED) && (state_d != ST_TRIGGERED);
    ev_inc  = (ev_cnt == 16'hFFFF) ? ev_cnt : ev_cnt + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_WARMUP;
      trigger      <= 1'b0;
      triggerStart <= 1'b0;
      eventDone    <= 1'b0;
      eventLength  <= '0;
      ev_cnt       <= '0;
      hold_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      trigger      <= (state_d == ST_TRIGGERED);
      triggerStart <= start_d;
      eventDone    <= done_d;
      if (start_d) begin
        ev_cnt <= '0;
      end else if (state_q == ST_TRIGGERED) begin
        ev_cnt <= ev_inc;
      end
      // Exit edge still counts as a TRIGGERED cycle, hence ev_inc.
      if (done_d) begin
        eventLength <= ev_inc;
        hold_cnt    <= holdoff;
      end else if (state_q == ST_HOLDOFF && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 16'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stalta_trigger_ctrl.sv
// Directed bench for stalta_trigger_ctrl with a zero-filled window buffer model driving the taps.
module tb_stalta_trigger_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] firstShort, lastShort, firstLong, lastLong;
  logic        initDone, enable;
  logic [7:0]  onThresh, offThresh;
  logic [15:0] holdoff;
  logic        trigger, triggerStart, eventDone;
  logic [15:0] eventLength;
  logic [1:0]  state;

`ifdef STALTA_ABS_EN
  localparam int M_NEG1000 = 1000;
`else
  localparam int M_NEG1000 = 64536;
`endif

  stalta_trigger_ctrl #(.shortSize(15), .longSize(31)) dut (
    .clock        (clock),
    .reset        (reset),
    .firstShort   (firstShort),
    .lastShort    (lastShort),
    .firstLong    (firstLong),
    .lastLong     (lastLong),
    .initDone     (initDone),
    .enable       (enable),
    .onThresh     (onThresh),
    .offThresh    (offThresh),
    .holdoff      (holdoff),
    .trigger      (trigger),
    .triggerStart (triggerStart),
    .eventDone    (eventDone),
    .eventLength  (eventLength),
    .state        (state)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] hist [0:30];
  int          fill_cnt;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample through the buffer model; returns 1 ns after the capturing edge.
  task automatic tick(input logic [15:0] s);
    firstShort = s;
    firstLong  = s;
    lastShort  = hist[14];
    lastLong   = hist[30];
    for (int i = 30; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    fill_cnt++;
    initDone = (fill_cnt >= 31);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    firstShort = '0;
    lastShort  = '0;
    firstLong  = '0;
    lastLong   = '0;
    initDone   = 1'b0;
    for (int i = 0; i < 31; i++) hist[i] = '0;
    fill_cnt = 0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int trig_cycles;
    bit seen;

    enable    = 1'b1;
    onThresh  = 8'h20;
    offThresh = 8'h18;
    holdoff   = 16'd2;
    do_reset();
    check("rst_state", 40'(state), 40'd0);
    check("rst_trigger", 40'(trigger), 40'd0);
    check("rst_start", 40'(triggerStart), 40'd0);
    check("rst_done", 40'(eventDone), 40'd0);
    check("rst_len", 40'(eventLength), 40'd0);
    check("rst_short_sum", 40'(dut.u_short_sum.sum), 40'd0);

    // Constant 100: ratio settles at 1.0, below 2.0.
    trig_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      tick(16'd100);
      if (trigger) trig_cycles++;
    end
    check("warmup_hold", 40'(state), 40'd0);
    tick(16'd100);
    check("warmup_to_armed", 40'(state), 40'd1);
    for (int i = 0; i < 10; i++) begin
      tick(16'd100);
      if (trigger) trig_cycles++;
    end
    check("const_no_trigger", 40'(trig_cycles), 40'd0);
    check("const_short_sum", 40'(dut.u_short_sum.sum), 40'd1500);
    check("const_long_sum", 40'(dut.u_long_sum.sum), 40'd3100);

    // Spike 500 then stream 100: trigger two cycles after the spike, off when ratio < 1.5.
    do_reset();
    for (int i = 0; i < 31; i++) tick(16'd0);
    check("zeros_armed", 40'(state), 40'd1);
    tick(16'd500);
    check("spike_not_yet", 40'(triggerStart), 40'd0);
    tick(16'd100);
    check("spike_start", 40'(triggerStart), 40'd1);
    check("spike_state", 40'(state), 40'd2);
    trig_cycles = trigger ? 1 : 0;
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(16'd100);
      if (trigger) trig_cycles++;
      if (eventDone) begin
        seen = 1'b1;
        check("done_no_start", 40'(triggerStart), 40'd0);
        check("done_trigger_low", 40'(trigger), 40'd0);
      end
    end
    check("done_seen", 40'(seen), 40'd1);
    check("len_vs_counted", 40'(eventLength), 40'(trig_cycles));
    check("len_value", 40'(eventLength), 40'd16);
    check("post_event_holdoff", 40'(state), 40'd3);
    for (int i = 0; i < 5; i++) tick(16'd100);
    check("len_stable", 40'(eventLength), 40'd16);
    check("back_to_armed", 40'(state), 40'd1);

    // off > on misconfigured: one-cycle events, hold-off timing, enable gating.
    enable    = 1'b0;
    onThresh  = 8'h0F;
    offThresh = 8'hFF;
    holdoff   = 16'd5;
    do_reset();
    for (int i = 0; i < 31; i++) tick(16'd100);
    check("hi_armed", 40'(state), 40'd1);
    for (int i = 0; i < 3; i++) tick(16'd100);
    check("enable_low_state", 40'(state), 40'd1);
    check("enable_low_trigger", 40'(trigger), 40'd0);
    enable = 1'b1;
    tick(16'd100);
    check("hi_trig_state", 40'(state), 40'd2);
    check("hi_trig_start", 40'(triggerStart), 40'd1);
    tick(16'd100);
    check("hi_exit_state", 40'(state), 40'd3);
    check("hi_exit_done", 40'(eventDone), 40'd1);
    check("hi_exit_start", 40'(triggerStart), 40'd0);
    check("hi_exit_len", 40'(eventLength), 40'd1);
    for (int i = 0; i < 5; i++) begin
      tick(16'd100);
      check("holdoff5_hold", 40'(state), 40'd3);
    end
    tick(16'd100);
    check("holdoff5_armed", 40'(state), 40'd1);
    tick(16'd100);
    check("holdoff5_retrig", 40'(state), 40'd2);
    holdoff = 16'd0;
    tick(16'd100);
    check("holdoff0_hold", 40'(state), 40'd3);
    tick(16'd100);
    check("holdoff0_armed", 40'(state), 40'd1);
    tick(16'd100);
    check("holdoff0_retrig", 40'(state), 40'd2);

    // Reset while TRIGGERED.
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_state", 40'(state), 40'd0);
    check("midrst_trigger", 40'(trigger), 40'd0);
    check("midrst_done", 40'(eventDone), 40'd0);
    check("midrst_start", 40'(triggerStart), 40'd0);
    check("midrst_len", 40'(eventLength), 40'd0);
    do_reset();
    tick(16'd0);
    check("midrst_no_done", 40'(eventDone), 40'd0);

    // Negative samples: rectified or taken unsigned depending on the build.
    onThresh  = 8'hFF;
    offThresh = 8'h00;
    do_reset();
    for (int i = 0; i < 3; i++) tick(16'hFC18);
    check("neg_short_3", 40'(dut.u_short_sum.sum), 40'(3 * M_NEG1000));
    check("neg_long_3", 40'(dut.u_long_sum.sum), 40'(3 * M_NEG1000));
    for (int i = 0; i < 17; i++) tick(16'hFC18);
    check("neg_short_20", 40'(dut.u_short_sum.sum), 40'(15 * M_NEG1000));
    check("neg_long_20", 40'(dut.u_long_sum.sum), 40'(20 * M_NEG1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stalta_trigger_ctrl.md
# stalta_trigger_ctrl

Event-detection controller for the STA/LTA window buffer. Consumes the buffer's four window taps and `initDone`, keeps running short- and long-window magnitude sums, and runs a hysteretic trigger state machine with hold-off. Emits a trigger level, start and end pulses, and the event length to downstream logging.

## Interface
Parameters:
- `shortSize`, 15: short-window length in samples. Must match the buffer instance.
- `longSize`, 31: long-window length in samples. Must match the buffer instance.

Ports:
- `clock`  in  1: sole clock. All logic is on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `firstShort`, `lastShort`, `firstLong`, `lastLong`  in  16 each: buffer taps. Each is the sample entering or leaving its window this cycle.
- `initDone`  in  1: buffer-filled flag from the buffer.
- `enable`  in  1: arms detection. Low blocks new triggers only.
- `onThresh`  in  8: trigger-on ratio, unsigned Q4.4.
- `offThresh`  in  8: trigger-off ratio, unsigned Q4.4.
- `holdoff`  in  16: dead-time cycles after an event.
- `trigger`  out  1: high while the state is TRIGGERED.
- `triggerStart`  out  1: one-cycle pulse on entry to TRIGGERED.
- `eventDone`  out  1: one-cycle pulse on exit from TRIGGERED.
- `eventLength`  out  16: cycles spent in TRIGGERED. Latched with `eventDone`.
- `state`  out  2: WARMUP=0, ARMED=1, TRIGGERED=2, HOLDOFF=3.

## Operation
- Magnitude `m(x)`:
  - With the config macro: two's-complement absolute value, zero-extended to 17 bits. −32768 gives 32768.
  - Without it: the sample is taken unsigned.
- Running sums, updated every cycle including WARMUP:
  - `shortSum += m(firstShort) − m(lastShort)`.
  - `longSum += m(firstLong) − m(lastLong)`.
  - Widths: 17 + $clog2(size+1). No saturation is needed; the buffer zero-fill keeps the sums exact.
- Comparison on registered sums, in 40-bit unsigned arithmetic:
  - `L = shortSum·longSize·16`.
  - `on = L > longSum·shortSize·onThresh`.
  - `off = L < longSum·shortSize·offThresh`.
  - If `longSum`=0, `on` is true iff `shortSum`>0.
- FSM:
  - WARMUP → ARMED when `initDone`=1.
  - ARMED → TRIGGERED when `enable` && `on`.
  - TRIGGERED → HOLDOFF when `off`. Runs regardless of `enable`.
  - HOLDOFF: load a counter with `holdoff`, decrement each cycle, → ARMED the cycle after it reads 0. `holdoff`=0 means a one-cycle HOLDOFF.
- Event counter:
  - Cleared on entry to TRIGGERED.
  - Incremented each TRIGGERED cycle.
  - Saturates at 0xFFFF.
  - Copied to `eventLength` on exit.
- Boundary rules:
  - HOLDOFF expiry goes to ARMED only. A trigger may occur on the following cycle at the earliest.
  - `on` and `off` both true (misconfigured, `offThresh` > `onThresh`): `off` wins in TRIGGERED, `on` wins in ARMED.
  - `enable` falling in TRIGGERED does not abort the event.
  - Threshold changes take effect on the next comparison.

## Timing
- Reset values: `state`=WARMUP; `trigger`, `triggerStart`, `eventDone`=0; `eventLength`=0; sums and counters=0.
- Reset mid-event clears everything. No `eventDone` pulse is emitted.
- Latency: taps at edge k → sums at edge k+1 → state transition at edge k+2. All outputs are registered.
- `triggerStart` and `eventDone` are never high in the same cycle.
- `eventLength` is stable until the next `eventDone`.

## Configuration
- `STALTA_ABS_EN` defined: the input is treated as signed and rectified.
- Not defined: samples are treated as unsigned magnitudes. The rectifier logic is omitted.

## Structure
- Shared package holds:
  - the state enum (`ST_WARMUP`, `ST_ARMED`, `ST_TRIGGERED`, `ST_HOLDOFF`);
  - the Q4.4 fraction width constant (4);
  - the compare width (40).
- One sub-module, `window_sum`:
  - parameterised on window size;
  - inputs: entering sample, leaving sample;
  - output: registered running sum;
  - contains the rectifier;
  - instantiated twice.

## Test plan
- Reset, constant stream 100, `onThresh`=0x20 → WARMUP until `initDone`. Sums settle at 1500/3100. Never triggers.
- Zeros until ARMED, then one sample 500 at `firstShort` → `triggerStart` two cycles later.
- Triggered, then stream returns to 100 with `offThresh`=0x18 → `eventDone` when the ratio drops below 1.5. `eventLength` equals the counted TRIGGERED cycles.
- `holdoff`=5 with a sustained high ratio → HOLDOFF for 6 cycles, then ARMED, then re-trigger on the next cycle.
- Stream of −1000 → with the macro, sums track 1000 per sample. Without it, sums use 64536.
- Reset asserted while TRIGGERED → all outputs 0 next cycle, no `eventDone`. `enable`=0 in ARMED with a high ratio → no trigger.
